fdtd_step_ctrl: RTL and testbench
=================================

Name: fdtd_step_ctrl

Overview:
Time-step sequencer for the 1-D FDTD engine. Per time step it walks the grid twice (H-field pass, then E-field pass) and then issues one source-injection cycle. It drives the mutually exclusive enables consumed by the Ez result selector (calc_Ez_en / calc_src_en) and the H-update datapath, plus the shared cell address. It runs a programmed number of steps per start and reports busy/done to the host register block.

Parameters:
GRID_SIZE, 200, number of grid cells (≥ 3)
ADDR_WIDTH, 8, width of cell address (2^ADDR_WIDTH ≥ GRID_SIZE)
STEP_WIDTH, 16, width of step counter / step count

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_N  input  1  synchronous active-low reset
start_i  input  1  start request, sampled only in IDLE
num_steps_i  input  STEP_WIDTH  number of time steps, latched on accepted start
src_pos_i  input  ADDR_WIDTH  source cell index, latched on accepted start
stall_i  input  1  datapath not ready; holds sequencer in place
calc_Hy_en_o  output  1  H-update phase active at cell_addr_o
calc_Ez_en_o  output  1  Ez-update phase active at cell_addr_o
calc_src_en_o  output  1  source-injection cycle at cell_addr_o
cell_addr_o  output  ADDR_WIDTH  current cell index
step_cnt_o  output  STEP_WIDTH  index of current time step (0-based)
busy_o  output  1  high from accepted start until DONE state exits
done_o  output  1  one-cycle pulse at end of run

Behaviour:
- Clock CLK; reset RST_N synchronous, active-low. While RST_N=0 at a rising edge: state=IDLE, all outputs 0, latched num_steps/src_pos = 0. Reset mid-run aborts immediately; no done pulse.
- All outputs registered (Moore, decoded from state/regs); no combinational path from inputs to outputs.
- At most one of calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o is high in any cycle (so Ez selector never sees 2'b11).
- States: IDLE, CALC_H, CALC_E, SRC, DONE.
- IDLE: busy_o=0, enables 0. start_i=1 & num_steps_i≠0 -> latch num_steps, latch src_pos (clamped to GRID_SIZE-1 if ≥ GRID_SIZE), step_cnt=0, addr=0, -> CALC_H. start_i=1 & num_steps_i=0 -> DONE (pulse, no enables). start_i while not IDLE is ignored.
- CALC_H: calc_Hy_en_o=1; addr 0..GRID_SIZE-2, +1 per cycle with stall_i=0. At addr=GRID_SIZE-2 with stall_i=0 -> CALC_E, addr=1.
- CALC_E: calc_Ez_en_o=1; addr 1..GRID_SIZE-1. At addr=GRID_SIZE-1 with stall_i=0 -> SRC, addr=latched src_pos.
- SRC: calc_src_en_o=1 for one un-stalled cycle. Then if step_cnt=num_steps-1 -> DONE (addr/step_cnt hold); else step_cnt+1, addr=0 -> CALC_H.
- DONE: done_o=1, busy_o=1, enables 0, for exactly one cycle -> IDLE. step_cnt_o keeps last value in IDLE until next start.
- Stall: stall_i=1 in CALC_H/CALC_E/SRC freezes state, addr, step_cnt; the active enable stays asserted. A cell counts as processed only on a cycle with enable=1 & stall_i=0. stall_i ignored in IDLE/DONE.
- Latency: first enable appears the cycle after start accepted. No stall: 2*GRID_SIZE-1 cycles per step; done_o asserted N*(2*GRID_SIZE-1) cycles after first enable cycle.
- Counters never wrap: addr bounded by state, step_cnt bounded by num_steps-1; num_steps_i = 2^STEP_WIDTH-1 is legal.

Test Plan:
- Reset/idle: hold RST_N=0 5 cycles mid-CALC_E -> next cycle all outputs 0, state IDLE, no done_o.
- Single step, GRID_SIZE=8, src_pos=3: start with num_steps=1 -> Hy_en for addr 0..6 (7 cycles), Ez_en for addr 1..7 (7 cycles), src_en 1 cycle at addr 3, done_o pulse next cycle; busy_o high 16 cycles.
- Multi-step: num_steps=3, GRID_SIZE=8 -> step_cnt_o 0,1,2, 45 enable cycles, one done_o; enables never overlap (assertion every cycle).
- Stall: stall_i=1 for 4 cycles at CALC_H addr=2 and for 2 cycles in SRC -> addr/enable held, total run extends by exactly 6 cycles, each cell processed once.
- Edge starts: num_steps=0 -> done_o one cycle after start, no enables; start_i pulsed during CALC_E -> ignored; src_pos_i=250 with GRID_SIZE=200 -> SRC addr=199.
- Back-to-back: start_i held high through DONE -> new run accepted in IDLE cycle after done_o, step_cnt restarts at 0.

Source files
------------

// File: rtl/fdtd_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// fdtd_step_ctrl_if
// Control/status bundle between the FDTD time-step sequencer and its
// surroundings (host register block, H/E update datapath, Ez result selector).
//
// Signals (direction seen from the sequencer):
//   start_i        in   start request, only honoured while idle
//   num_steps_i    in   number of time steps for the run
//   src_pos_i      in   source-injection cell index
//   stall_i        in   datapath not ready, freeze the sequencer
//   calc_Hy_en_o   out  H-update active at cell_addr_o
//   calc_Ez_en_o   out  Ez-update active at cell_addr_o
//   calc_src_en_o  out  source injection at cell_addr_o
//   cell_addr_o    out  current cell index
//   step_cnt_o     out  current time-step index (0-based)
//   busy_o         out  run in progress (includes the done cycle)
//   done_o         out  one-cycle end-of-run pulse
//
// Modports: master = host/datapath side, slave = sequencer.
// ---------------------------------------------------------------------------
interface fdtd_step_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int STEP_WIDTH = 16
);
    logic                  start_i;
    logic [STEP_WIDTH-1:0] num_steps_i;
    logic [ADDR_WIDTH-1:0] src_pos_i;
    logic                  stall_i;
    logic                  calc_Hy_en_o;
    logic                  calc_Ez_en_o;
    logic                  calc_src_en_o;
    logic [ADDR_WIDTH-1:0] cell_addr_o;
    logic [STEP_WIDTH-1:0] step_cnt_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output start_i,
        output num_steps_i,
        output src_pos_i,
        output stall_i,
        input  calc_Hy_en_o,
        input  calc_Ez_en_o,
        input  calc_src_en_o,
        input  cell_addr_o,
        input  step_cnt_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  num_steps_i,
        input  src_pos_i,
        input  stall_i,
        output calc_Hy_en_o,
        output calc_Ez_en_o,
        output calc_src_en_o,
        output cell_addr_o,
        output step_cnt_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/fdtd_step_ctrl.sv
// ---------------------------------------------------------------------------
// fdtd_step_ctrl
// Time-step sequencer for the 1-D FDTD engine. Each time step walks the grid
// for the H-field update (cells 0..GRID_SIZE-2), then for the E-field update
// (cells 1..GRID_SIZE-1), then spends one cycle on source injection at the
// latched source cell. A run executes a programmed number of steps and ends
// with a single done pulse.
//
// Ports:
//   CLK    system clock, rising edge
//   RST_N  synchronous active-low reset
//   ctl    fdtd_step_ctrl_if.slave (start/num_steps/src_pos/stall in;
//          enables, cell address, step index, busy, done out)
//
// State table:
//   IDLE   | waiting for start, enables low, step_cnt holds last run value
//   CALC_H | H-update sweep, calc_Hy_en high
//   CALC_E | E-update sweep, calc_Ez_en high
//   SRC    | one source-injection cycle, calc_src_en high
//   DONE   | done/busy high for one cycle, then back to IDLE
//
// Every output is decoded from registered state only, so the three enables
// are mutually exclusive by construction and nothing on ctl feeds through
// combinationally to the outputs.
// ---------------------------------------------------------------------------
module fdtd_step_ctrl #(
    parameter int GRID_SIZE  = 200,
    parameter int ADDR_WIDTH = 8,
    parameter int STEP_WIDTH = 16
) (
    input logic              CLK,
    input logic              RST_N,
    fdtd_step_ctrl_if.slave  ctl
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC_H = 3'd1,
        CALC_E = 3'd2,
        SRC    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] H_LAST    = ADDR_WIDTH'(GRID_SIZE - 2);
    localparam logic [ADDR_WIDTH-1:0] E_LAST    = ADDR_WIDTH'(GRID_SIZE - 1);
    localparam logic [STEP_WIDTH-1:0] STEP_ZERO = '0;
    localparam logic [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [STEP_WIDTH-1:0] step_q,      step_d;
    logic [STEP_WIDTH-1:0] num_steps_q, num_steps_d;
    logic [ADDR_WIDTH-1:0] src_pos_q,   src_pos_d;

    logic [ADDR_WIDTH-1:0] src_clamped;
    logic                  last_step;

    // Out-of-range source positions are pulled onto the last cell so the
    // injection cycle never addresses a non-existent cell.
    assign src_clamped = (ctl.src_pos_i > E_LAST) ? E_LAST : ctl.src_pos_i;

    // num_steps_q is never zero while a sweep is running (a zero-step start
    // goes straight to DONE), so the subtraction cannot wrap here. Comparing
    // against num_steps-1 instead of incrementing first keeps step_cnt from
    // ever reaching num_steps, which matters when num_steps is all ones.
    assign last_step = (step_q == (num_steps_q - STEP_ONE));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            addr_q      <= ADDR_ZERO;
            step_q      <= STEP_ZERO;
            num_steps_q <= STEP_ZERO;
            src_pos_q   <= ADDR_ZERO;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            step_q      <= step_d;
            num_steps_q <= num_steps_d;
            src_pos_q   <= src_pos_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        step_d      = step_q;
        num_steps_d = num_steps_q;
        src_pos_d   = src_pos_q;

        case (state_q)
            IDLE: begin
                if (ctl.start_i) begin
                    num_steps_d = ctl.num_steps_i;
                    src_pos_d   = src_clamped;
                    step_d      = STEP_ZERO;
                    addr_d      = ADDR_ZERO;
                    // A zero-step run still reports completion to the host.
                    if (ctl.num_steps_i != STEP_ZERO) begin
                        state_d = CALC_H;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            CALC_H: begin
                if (!ctl.stall_i) begin
                    if (addr_q == H_LAST) begin
                        state_d = CALC_E;
                        addr_d  = ADDR_ONE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                    end
                end
            end

            CALC_E: begin
                if (!ctl.stall_i) begin
                    if (addr_q == E_LAST) begin
                        state_d = SRC;
                        addr_d  = src_pos_q;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                    end
                end
            end

            SRC: begin
                if (!ctl.stall_i) begin
                    if (last_step) begin
                        // Address and step index stay visible through DONE
                        // and into IDLE for the host to read back.
                        state_d = DONE;
                    end else begin
                        state_d = CALC_H;
                        step_d  = step_q + STEP_ONE;
                        addr_d  = ADDR_ZERO;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ctl.calc_Hy_en_o  = (state_q == CALC_H);
    assign ctl.calc_Ez_en_o  = (state_q == CALC_E);
    assign ctl.calc_src_en_o = (state_q == SRC);
    assign ctl.cell_addr_o   = addr_q;
    assign ctl.step_cnt_o    = step_q;
    assign ctl.busy_o        = (state_q != IDLE);
    assign ctl.done_o        = (state_q == DONE);

endmodule

// File: tb/tb_fdtd_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fdtd_step_ctrl
// Scoreboard bench for fdtd_step_ctrl. The stimulus process pushes the
// expected sequence of processed cells / done events for each run; the
// monitor pops one entry for every cycle in which the sequencer processes a
// cell (enable high, no stall) or pulses done, and compares. A second,
// full-size instance checks source-position clamping.
// ---------------------------------------------------------------------------
module tb_fdtd_step_ctrl;

    localparam int G   = 8;
    localparam int AW  = 4;
    localparam int SW  = 16;
    localparam int BG  = 200;
    localparam int BAW = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fdtd_step_ctrl_if #(.ADDR_WIDTH(AW),  .STEP_WIDTH(SW)) s_if ();
    fdtd_step_ctrl_if #(.ADDR_WIDTH(BAW), .STEP_WIDTH(SW)) b_if ();

    fdtd_step_ctrl #(.GRID_SIZE(G), .ADDR_WIDTH(AW), .STEP_WIDTH(SW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .ctl   (s_if)
    );

    fdtd_step_ctrl #(.GRID_SIZE(BG), .ADDR_WIDTH(BAW), .STEP_WIDTH(SW)) dut_big (
        .CLK   (clk),
        .RST_N (rst_n),
        .ctl   (b_if)
    );

    // kind: 1 = H cell, 2 = E cell, 3 = source, 4 = done. -1 = don't care.
    typedef struct {
        int kind;
        int addr;
        int step;
        int blen;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int errors   = 0;
    int timeouts = 0;
    bit final_req = 1'b0;
    bit mon_done  = 1'b0;

    // Expected processed-cell sequence of one run. blen is the number of
    // busy cycles including the done cycle: (2G-1) per step plus the done
    // cycle plus any stalled cycles.
    task automatic push_run(input int n, input int src, input int extra);
        exp_t e;
        for (int s = 0; s < n; s++) begin
            for (int a = 0; a <= G - 2; a++) begin
                e = '{kind: 1, addr: a, step: s, blen: -1};
                sb_q.push_back(e);
            end
            for (int a = 1; a <= G - 1; a++) begin
                e = '{kind: 2, addr: a, step: s, blen: -1};
                sb_q.push_back(e);
            end
            e = '{kind: 3, addr: src, step: s, blen: -1};
            sb_q.push_back(e);
        end
        e = '{kind: 4, addr: (n == 0) ? -1 : src, step: (n == 0) ? -1 : n - 1,
              blen: n * (2 * G - 1) + 1 + extra};
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int   bcnt = 0;
    bit   prev_rst_low = 1'b0;
    bit   have_prev = 1'b0;
    bit   prev_stall = 1'b0;
    int   prev_en = 0;
    int   prev_addr = 0;
    int   big_src_cnt = 0;
    int   big_done_cnt = 0;

    always @(negedge clk) begin : monitor
        int   en;
        int   kind;
        int   nz_s;
        int   nz_b;
        exp_t e;

        en   = {29'd0, s_if.calc_Hy_en_o, s_if.calc_Ez_en_o, s_if.calc_src_en_o};
        nz_s = (s_if.calc_Hy_en_o | s_if.calc_Ez_en_o | s_if.calc_src_en_o |
                s_if.busy_o | s_if.done_o | (|s_if.cell_addr_o) | (|s_if.step_cnt_o)) ? 1 : 0;
        nz_b = (b_if.calc_Hy_en_o | b_if.calc_Ez_en_o | b_if.calc_src_en_o |
                b_if.busy_o | b_if.done_o | (|b_if.cell_addr_o) | (|b_if.step_cnt_o)) ? 1 : 0;

        if (!rst_n) begin
            if (prev_rst_low) begin
                chk("reset_outputs_zero", nz_s, 0);
                chk("reset_outputs_zero_big", nz_b, 0);
            end
            prev_rst_low = 1'b1;
            bcnt         = 0;
            have_prev    = 1'b0;
        end else begin
            if (prev_rst_low) begin
                chk("post_reset_outputs_zero", nz_s, 0);
            end
            prev_rst_low = 1'b0;

            chk("enables_exclusive", ($countones(en) > 1) ? 1 : 0, 0);
            chk("enables_exclusive_big",
                ($countones({b_if.calc_Hy_en_o, b_if.calc_Ez_en_o, b_if.calc_src_en_o}) > 1) ? 1 : 0, 0);

            if (have_prev && prev_stall && prev_en != 0) begin
                chk("stall_hold_addr", int'(s_if.cell_addr_o), prev_addr);
                chk("stall_hold_enable", en, prev_en);
            end

            if (s_if.busy_o) bcnt++;

            kind = s_if.calc_Hy_en_o ? 1 : s_if.calc_Ez_en_o ? 2 : s_if.calc_src_en_o ? 3 : 0;
            if (s_if.done_o) kind = 4;

            if (kind != 0 && (kind == 4 || !s_if.stall_i)) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event_kind", kind, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("event_kind", kind, e.kind);
                    if (e.addr >= 0) chk("event_addr", int'(s_if.cell_addr_o), e.addr);
                    if (e.step >= 0) chk("event_step", int'(s_if.step_cnt_o), e.step);
                    if (kind == 4 && e.blen >= 0) chk("busy_cycles", bcnt, e.blen);
                end
            end
            if (s_if.done_o) bcnt = 0;

            have_prev  = 1'b1;
            prev_stall = s_if.stall_i;
            prev_en    = en;
            prev_addr  = int'(s_if.cell_addr_o);

            if (b_if.calc_src_en_o && !b_if.stall_i) begin
                big_src_cnt++;
                chk("big_src_clamp_addr", int'(b_if.cell_addr_o), 199);
            end
            if (b_if.done_o) big_done_cnt++;
        end

        if (final_req && !mon_done) begin
            chk("scoreboard_empty", sb_q.size(), 0);
            chk("big_src_events", big_src_cnt, 1);
            chk("big_done_events", big_done_cnt, 1);
            chk("wait_timeouts", timeouts, 0);
            mon_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // what: 0 = Hy at addr 2, 1 = Ez, 2 = src, 3 = done, 4 = big done
    task automatic wait_for(input int what, input int budget);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            tick();
            n++;
            case (what)
                0:       hit = s_if.calc_Hy_en_o && (s_if.cell_addr_o == 4'd2);
                1:       hit = s_if.calc_Ez_en_o;
                2:       hit = s_if.calc_src_en_o;
                3:       hit = s_if.done_o;
                default: hit = b_if.done_o;
            endcase
        end
        if (!hit) timeouts++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            timeouts++;
            sb_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic start_run(input int n, input int src);
        s_if.start_i     = 1'b1;
        s_if.num_steps_i = SW'(n);
        s_if.src_pos_i   = AW'(src);
        tick();
        s_if.start_i     = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        s_if.start_i     = 1'b0;
        s_if.num_steps_i = '0;
        s_if.src_pos_i   = '0;
        s_if.stall_i     = 1'b0;
        b_if.start_i     = 1'b0;
        b_if.num_steps_i = '0;
        b_if.src_pos_i   = '0;
        b_if.stall_i     = 1'b0;
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // single step, src 3
        push_run(1, 3, 0);
        start_run(1, 3);
        drain(200);

        // three steps; src 12 clamps to 7; start during CALC_E ignored
        push_run(3, 7, 0);
        start_run(3, 12);
        wait_for(1, 100);
        s_if.start_i     = 1'b1;
        s_if.num_steps_i = SW'(5);
        tick();
        s_if.start_i     = 1'b0;
        drain(300);

        // stall 4 cycles at H addr 2, 2 cycles in SRC
        push_run(1, 5, 6);
        start_run(1, 5);
        wait_for(0, 50);
        s_if.stall_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        s_if.stall_i = 1'b0;
        wait_for(2, 50);
        s_if.stall_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_if.stall_i = 1'b0;
        drain(200);

        // zero-step run: done only
        push_run(0, -1, 0);
        start_run(0, 1);
        drain(20);

        // back-to-back with start held through DONE
        push_run(1, 2, 0);
        push_run(1, 2, 0);
        s_if.start_i     = 1'b1;
        s_if.num_steps_i = SW'(1);
        s_if.src_pos_i   = AW'(2);
        wait_for(3, 100);
        tick();
        tick();
        s_if.start_i = 1'b0;
        drain(200);

        // reset mid-CALC_E: no done afterwards
        push_run(2, 3, 0);
        start_run(2, 3);
        wait_for(1, 100);
        rst_n = 1'b0;
        tick();
        sb_q.delete();
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (40) tick();

        // full-size grid, source index 250 clamps to 199
        b_if.start_i     = 1'b1;
        b_if.num_steps_i = SW'(1);
        b_if.src_pos_i   = BAW'(250);
        tick();
        b_if.start_i     = 1'b0;
        wait_for(4, 1000);
        repeat (3) tick();

        final_req = 1'b1;
        repeat (3) tick();
        if (!mon_done) begin
            $display("FAIL monitor_final: got 0 expected 1");
            $fatal(1, "monitor did not complete final checks");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
